// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/memory handshake and datapath control bundle for multicycle_control
interface multicycle_control_if #(
   parameter int ALUOP_W = 3,
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic               mem_ready;
   logic               mem_req;
   logic               pc_write;
   logic               pc_write_beq;
   logic               pc_write_bne;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic [1:0]         reg_dst;
   logic [1:0]         mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic [1:0]         pc_source;
   logic               instr_done;
   logic               fault;
   logic [STATE_W-1:0] state_o;

   modport master (
      input  opcode, mem_ready,
      output mem_req, pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, fault, state_o
   );

   modport slave (
      output opcode, mem_ready,
      input  mem_req, pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, fault, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with memory stall handshake, timeout watchdog and sticky fault
module multicycle_control #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5,
   parameter int STATE_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_control_if.master  bus
);
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_IEXEC  = 4'd9;
   localparam logic [3:0] S_IWB    = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_JAL    = 4'd12;
   localparam logic [3:0] S_FAULT  = 4'd15;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       w_next;
   logic             w_wait_state;
   logic             w_waiting;
   logic             w_timeout;

   logic       w_mem_req, w_pc_write, w_pc_write_beq, w_pc_write_bne, w_iord;
   logic       w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_alu_src_a;
   logic       w_instr_done, w_fault;
   logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
   logic [2:0] w_alu_op;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_waiting    = w_wait_state && !bus.mem_ready;
   // The count holds completed wait cycles, so the MEM_TIMEOUT-th unanswered cycle is the one that faults.
   assign w_timeout    = w_waiting && (r_cnt == CNT_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (bus.mem_ready)  w_next = S_DECODE;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW:   w_next = S_MEMADR;
               OP_R:           w_next = S_EXEC;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
               OP_ORI, OP_XORI, OP_LUI: w_next = S_IEXEC;
               OP_J:           w_next = S_JUMP;
               OP_JAL:         w_next = S_JAL;
               default:        w_next = S_FAULT;
            endcase
         end
         S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (bus.mem_ready)  w_next = S_MEMWB;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_MEMWR: begin
            if (bus.mem_ready)  w_next = S_FETCH;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_EXEC:  w_next = S_RWB;
         S_IEXEC: w_next = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP, S_JAL: w_next = S_FETCH;
         S_FAULT: w_next = S_FAULT;
         default: w_next = S_FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_waiting ? r_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      w_mem_req      = 1'b0;
      w_pc_write     = 1'b0;
      w_pc_write_beq = 1'b0;
      w_pc_write_bne = 1'b0;
      w_iord         = 1'b0;
      w_mem_read     = 1'b0;
      w_mem_write    = 1'b0;
      w_ir_write     = 1'b0;
      w_reg_dst      = 2'b00;
      w_mem_to_reg   = 2'b00;
      w_reg_write    = 1'b0;
      w_alu_src_a    = 1'b0;
      w_alu_src_b    = 2'b00;
      w_alu_op       = 3'b000;
      w_pc_source    = 2'b00;
      w_instr_done   = 1'b0;
      w_fault        = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               w_mem_req   = 1'b1;
               w_mem_read  = 1'b1;
               w_alu_src_b = 2'b01;
               w_ir_write  = bus.mem_ready;
               w_pc_write  = bus.mem_ready;
            end
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR: begin
               w_alu_src_a = 1'b1;
               w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               w_mem_req  = 1'b1;
               w_mem_read = 1'b1;
               w_iord     = 1'b1;
            end
            S_MEMWB: begin
               w_reg_write  = 1'b1;
               w_mem_to_reg = 2'b01;
               w_instr_done = 1'b1;
            end
            S_MEMWR: begin
               w_mem_req    = 1'b1;
               w_mem_write  = 1'b1;
               w_iord       = 1'b1;
               w_instr_done = bus.mem_ready;
            end
            S_EXEC: begin
               w_alu_src_a = 1'b1;
               w_alu_op    = 3'b010;
            end
            S_RWB: begin
               w_reg_write  = 1'b1;
               w_reg_dst    = 2'b01;
               w_instr_done = 1'b1;
            end
            S_BRANCH: begin
               w_alu_src_a    = 1'b1;
               w_alu_op       = 3'b001;
               w_pc_source    = 2'b01;
               w_pc_write_beq = (bus.opcode == OP_BEQ);
               w_pc_write_bne = (bus.opcode == OP_BNE);
               w_instr_done   = 1'b1;
            end
            S_IEXEC: begin
               w_alu_src_a = 1'b1;
               w_alu_src_b = 2'b10;
               case (bus.opcode)
                  OP_ADDI:           w_alu_op = 3'b011;
                  OP_SLTI, OP_SLTIU: w_alu_op = 3'b010;
                  OP_ANDI:           w_alu_op = 3'b100;
                  OP_ORI:            w_alu_op = 3'b101;
                  OP_XORI:           w_alu_op = 3'b110;
                  OP_LUI:            w_alu_op = 3'b111;
                  default:           w_alu_op = 3'b000;
               endcase
            end
            S_IWB: begin
               w_reg_write  = 1'b1;
               w_instr_done = 1'b1;
            end
            S_JUMP: begin
               w_pc_write   = 1'b1;
               w_pc_source  = 2'b10;
               w_instr_done = 1'b1;
            end
            S_JAL: begin
               w_pc_write   = 1'b1;
               w_pc_source  = 2'b10;
               w_reg_write  = 1'b1;
               w_reg_dst    = 2'b10;
               w_mem_to_reg = 2'b10;
               w_instr_done = 1'b1;
            end
            S_FAULT: w_fault = 1'b1;
            default: w_fault = 1'b0;
         endcase
      end
   end

   assign bus.mem_req      = w_mem_req;
   assign bus.pc_write     = w_pc_write;
   assign bus.pc_write_beq = w_pc_write_beq;
   assign bus.pc_write_bne = w_pc_write_bne;
   assign bus.iord         = w_iord;
   assign bus.mem_read     = w_mem_read;
   assign bus.mem_write    = w_mem_write;
   assign bus.ir_write     = w_ir_write;
   assign bus.reg_dst      = w_reg_dst;
   assign bus.mem_to_reg   = w_mem_to_reg;
   assign bus.reg_write    = w_reg_write;
   assign bus.alu_src_a    = w_alu_src_a;
   assign bus.alu_src_b    = w_alu_src_b;
   assign bus.alu_op       = ALUOP_W'(w_alu_op);
   assign bus.pc_source    = w_pc_source;
   assign bus.instr_done   = w_instr_done;
   assign bus.fault        = w_fault;
   assign bus.state_o      = rst_n ? STATE_W'(r_state) : '0;
endmodule
